// File: rtl/wash_sequencer.sv
// wash_sequencer: washing machine phase sequencer.
// Runs FILL/WASH/DRAIN, then rinse cycles of FILL/RINSE/DRAIN, then SPIN and DONE.
// start_pause edges start, pause and resume. An open door forces a pause.
// Optional feature macro: WASH_SOAK_EN.
//   Defined:   heavy mode inserts a SOAK phase between the first FILL and WASH.
//   Undefined: SOAK is never entered.
module wash_sequencer #(
   parameter int CNT_W       = 16,
   parameter int FILL_TICKS  = 4,
   parameter int SOAK_TICKS  = 4,
   parameter int WASH_TICKS  = 8,
   parameter int RINSE_TICKS = 6,
   parameter int DRAIN_TICKS = 3,
   parameter int SPIN_TICKS  = 5,
   parameter int DIR_PERIOD  = 2,
   parameter int MAX_RINSES  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_pause,
   input  logic [1:0] mode_select,
   input  logic       door_sensor,
   output logic       water_valve,
   output logic       drain_valve,
   output logic       motor,
   output logic [1:0] motor_dir,
   output logic [3:0] state_code,
   output logic       paused,
   output logic       done
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_FILL  = 4'd1,
      S_SOAK  = 4'd2,
      S_WASH  = 4'd3,
      S_DRAIN = 4'd4,
      S_RINSE = 4'd5,
      S_SPIN  = 4'd6,
      S_DONE  = 4'd7
   } state_t;

   localparam logic [1:0] MODE_QUICK  = 2'b00;
   localparam logic [1:0] MODE_NORMAL = 2'b01;
   localparam logic [1:0] MODE_HEAVY  = 2'b10;

   localparam int unsigned RINSE_MAX = (MAX_RINSES > 2) ? MAX_RINSES : 2;
   localparam int unsigned RW        = $clog2(RINSE_MAX + 1);

   localparam logic [CNT_W-1:0] DIR_LAST = CNT_W'(DIR_PERIOD - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] timer, timer_n;
   logic [CNT_W-1:0] dcnt, dcnt_n;
   logic             dir, dir_n;          // 0 = cw, 1 = ccw
   logic             pause_q, pause_n;
   logic [1:0]       mode, mode_n;
   logic [RW-1:0]    rinses, rinses_n;    // rinse cycles still to run
   logic             rphase, rphase_n;    // next FILL belongs to a rinse cycle
   logic             sp_prev;
   logic             edge_det;
   logic             enter;
   state_t           nxt;

   // Phase timer load value (length - 1) for the phase being entered.
   function automatic logic [CNT_W-1:0] phase_load(input state_t s, input logic [1:0] m);
      logic [CNT_W-1:0] base;
      logic [CNT_W-1:0] len;
      base = CNT_W'(WASH_TICKS);
      len  = '0;
      case (s)
         S_FILL:  len = CNT_W'(FILL_TICKS);
         S_SOAK:  len = CNT_W'(SOAK_TICKS);
         S_WASH: begin
            case (m)
               MODE_NORMAL: len = base + base;
               MODE_HEAVY:  len = base + base + base;
               default:     len = base;
            endcase
         end
         S_RINSE: len = CNT_W'(RINSE_TICKS);
         S_DRAIN: len = CNT_W'(DRAIN_TICKS);
         S_SPIN:  len = CNT_W'(SPIN_TICKS);
         default: len = CNT_W'(1);
      endcase
      return len - CNT_W'(1);
   endfunction

   // Number of rinse cycles for each mode; spin-only has none.
   function automatic logic [RW-1:0] rinse_total(input logic [1:0] m);
      case (m)
         MODE_QUICK:  return RW'(1);
         MODE_NORMAL: return RW'(2);
         MODE_HEAVY:  return RW'(MAX_RINSES);
         default:     return '0;
      endcase
   endfunction

   assign edge_det = start_pause & ~sp_prev;

   // Successor of a running phase once its timer has expired.
   always_comb begin
      nxt = state;
      case (state)
         S_FILL: begin
            if (rphase) begin
               nxt = S_RINSE;
            end else begin
`ifdef WASH_SOAK_EN
               nxt = (mode == MODE_HEAVY) ? S_SOAK : S_WASH;
`else
               nxt = S_WASH;
`endif
            end
         end
         S_SOAK:  nxt = S_WASH;
         S_WASH:  nxt = S_DRAIN;
         S_RINSE: nxt = S_DRAIN;
         S_DRAIN: nxt = (rinses != '0) ? S_FILL : S_SPIN;
         S_SPIN:  nxt = S_DONE;
         default: nxt = state;
      endcase
   end

   // Next-state logic: start, pause/resume, timer countdown and phase changes.
   always_comb begin
      state_n  = state;
      timer_n  = timer;
      dcnt_n   = dcnt;
      dir_n    = dir;
      pause_n  = pause_q;
      mode_n   = mode;
      rinses_n = rinses;
      rphase_n = rphase;
      enter    = 1'b0;

      case (state)
         S_IDLE: begin
            if (edge_det && !door_sensor) begin
               mode_n   = mode_select;
               rinses_n = rinse_total(mode_select);
               rphase_n = 1'b0;
               pause_n  = 1'b0;
               state_n  = (mode_select == 2'b11) ? S_DRAIN : S_FILL;
               enter    = 1'b1;
            end
         end
         S_DONE: begin
            if (edge_det || door_sensor) begin
               state_n  = S_IDLE;
               timer_n  = '0;
               dcnt_n   = '0;
               dir_n    = 1'b0;
               rinses_n = '0;
               rphase_n = 1'b0;
            end
         end
         default: begin
            // A cycle that pauses or resumes is not a run cycle: nothing advances.
            if (pause_q) begin
               if (edge_det && !door_sensor) begin
                  pause_n = 1'b0;
               end
            end else if (edge_det || door_sensor) begin
               pause_n = 1'b1;
            end else if (timer == '0) begin
               state_n = nxt;
               enter   = 1'b1;
               if (state == S_DRAIN && rinses != '0) begin
                  rinses_n = rinses - RW'(1);
                  rphase_n = 1'b1;
               end
            end else begin
               timer_n = timer - CNT_W'(1);
               if (state == S_WASH || state == S_RINSE) begin
                  if (dcnt == DIR_LAST) begin
                     dcnt_n = '0;
                     dir_n  = ~dir;
                  end else begin
                     dcnt_n = dcnt + CNT_W'(1);
                  end
               end
            end
         end
      endcase

      if (enter) begin
         timer_n = (state_n == S_DONE) ? '0 : phase_load(state_n, mode_n);
         dcnt_n  = '0;
         dir_n   = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         timer   <= '0;
         dcnt    <= '0;
         dir     <= 1'b0;
         pause_q <= 1'b0;
         mode    <= '0;
         rinses  <= '0;
         rphase  <= 1'b0;
         sp_prev <= 1'b1;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         dcnt    <= dcnt_n;
         dir     <= dir_n;
         pause_q <= pause_n;
         mode    <= mode_n;
         rinses  <= rinses_n;
         rphase  <= rphase_n;
         sp_prev <= start_pause;
      end
   end

   // Output decode from registered state only.
   always_comb begin
      water_valve = 1'b0;
      drain_valve = 1'b0;
      motor       = 1'b0;
      motor_dir   = 2'b00;
      state_code  = state;
      paused      = pause_q;
      done        = (state == S_DONE);
      if (!pause_q) begin
         case (state)
            S_FILL:  water_valve = 1'b1;
            S_DRAIN: drain_valve = 1'b1;
            S_WASH, S_RINSE: begin
               motor     = 1'b1;
               motor_dir = dir ? 2'b10 : 2'b01;
            end
            S_SPIN: begin
               motor       = 1'b1;
               drain_valve = 1'b1;
               motor_dir   = 2'b01;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wash_sequencer.sv
// Testbench for wash_sequencer: directed timeline checks plus randomized
// stimulus compared cycle by cycle against a phase-list reference model.
module tb_wash_sequencer;

   localparam int FILL_T  = 4;
   localparam int SOAK_T  = 4;
   localparam int WASH_T  = 8;
   localparam int RINSE_T = 6;
   localparam int DRAIN_T = 3;
   localparam int SPIN_T  = 5;
   localparam int DIR_P   = 2;
   localparam int MAX_R   = 3;

   logic       clk = 1'b0;
   logic       reset, start_pause, door_sensor;
   logic [1:0] mode_select;
   logic       water_valve, drain_valve, motor, paused, done;
   logic [1:0] motor_dir;
   logic [3:0] state_code;
   logic [10:0] obs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wash_sequencer #(
      .CNT_W(16), .FILL_TICKS(FILL_T), .SOAK_TICKS(SOAK_T), .WASH_TICKS(WASH_T),
      .RINSE_TICKS(RINSE_T), .DRAIN_TICKS(DRAIN_T), .SPIN_TICKS(SPIN_T),
      .DIR_PERIOD(DIR_P), .MAX_RINSES(MAX_R)
   ) dut (
      .clk(clk), .reset(reset), .start_pause(start_pause), .mode_select(mode_select),
      .door_sensor(door_sensor), .water_valve(water_valve), .drain_valve(drain_valve),
      .motor(motor), .motor_dir(motor_dir), .state_code(state_code), .paused(paused),
      .done(done)
   );

   assign obs = {state_code, paused, done, water_valve, drain_valve, motor, motor_dir};

   // Reference model: a program of (state code, length) phases walked in order.
   int codes[$];
   int lens[$];
   int idx, rem, elapsed;
   bit m_run, m_done, m_paused, m_prev;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void build(input logic [1:0] m);
      int washes, rinses;
      codes.delete();
      lens.delete();
      if (m == 2'b11) begin
         codes.push_back(4); lens.push_back(DRAIN_T);
         codes.push_back(6); lens.push_back(SPIN_T);
         return;
      end
      washes = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 3;
      rinses = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : MAX_R;
      codes.push_back(1); lens.push_back(FILL_T);
`ifdef WASH_SOAK_EN
      if (m == 2'b10) begin
         codes.push_back(2); lens.push_back(SOAK_T);
      end
`endif
      codes.push_back(3); lens.push_back(WASH_T * washes);
      codes.push_back(4); lens.push_back(DRAIN_T);
      for (int r = 0; r < rinses; r++) begin
         codes.push_back(1); lens.push_back(FILL_T);
         codes.push_back(5); lens.push_back(RINSE_T);
         codes.push_back(4); lens.push_back(DRAIN_T);
      end
      codes.push_back(6); lens.push_back(SPIN_T);
   endfunction

   task automatic model_step();
      bit e;
      if (reset) begin
         m_run = 0; m_done = 0; m_paused = 0; m_prev = 1;
         return;
      end
      e = start_pause && !m_prev;
      m_prev = start_pause;
      if (m_done) begin
         if (e || door_sensor) m_done = 0;
      end else if (!m_run) begin
         if (e && !door_sensor) begin
            build(mode_select);
            idx = 0; rem = lens[0]; elapsed = 0; m_run = 1; m_paused = 0;
         end
      end else if (m_paused) begin
         if (e && !door_sensor) m_paused = 0;
      end else if (e || door_sensor) begin
         m_paused = 1;
      end else begin
         elapsed++;
         rem--;
         if (rem == 0) begin
            idx++;
            if (idx == codes.size()) begin
               m_run = 0; m_done = 1;
            end else begin
               rem = lens[idx]; elapsed = 0;
            end
         end
      end
   endtask

   function automatic logic [10:0] exp_vec();
      logic [3:0] sc;
      logic p, dn, w, dr, mo;
      logic [1:0] md;
      sc = 0; p = 0; dn = 0; w = 0; dr = 0; mo = 0; md = 0;
      if (m_done) begin
         sc = 7; dn = 1;
      end else if (m_run) begin
         sc = 4'(codes[idx]);
         p  = m_paused;
         if (!m_paused) begin
            case (codes[idx])
               1: w = 1;
               4: dr = 1;
               3, 5: begin
                  mo = 1;
                  md = (((elapsed / DIR_P) % 2) == 1) ? 2'b10 : 2'b01;
               end
               6: begin mo = 1; dr = 1; md = 2'b01; end
               default: ;
            endcase
         end
      end
      return {sc, p, dn, w, dr, mo, md};
   endfunction

   // One clock: drive inputs, advance DUT and model, compare full output vector.
   task automatic tick(input bit r, input bit sp, input logic [1:0] m, input bit d);
      reset = r; start_pause = sp; mode_select = m; door_sensor = d;
      @(posedge clk);
      model_step();
      #1;
      check_eq("outputs", 32'(obs), 32'(exp_vec()));
   endtask

   task automatic finish_run();
      for (int i = 0; i < 300 && !done; i++) tick(0, 0, 2'b00, 0);
      check_eq("reach_done", 32'(done), 32'd1);
      tick(0, 1, 2'b00, 0);
      tick(0, 0, 2'b00, 0);
      check_eq("done_exit", 32'(state_code), 32'd0);
   endtask

   logic [1:0] qdir [4];
   int door_hold;

   initial begin
      qdir[0] = 2'b01; qdir[1] = 2'b01; qdir[2] = 2'b10; qdir[3] = 2'b10;

      tick(1, 1, 2'b00, 0);
      tick(1, 0, 2'b00, 0);
      check_eq("reset_state", 32'(obs), 32'd0);
      tick(0, 0, 2'b00, 0);

      // Quick mode timeline, edge at cycle 0.
      for (int c = 0; c < 34; c++) begin
         tick(0, c == 0, 2'b00, 0);
         case (c + 1)
            1:  check_eq("q_fill1", 32'(state_code), 32'd1);
            4:  check_eq("q_fill1_end", 32'(state_code), 32'd1);
            5:  check_eq("q_wash", 32'(state_code), 32'd3);
            12: check_eq("q_wash_end", 32'(state_code), 32'd3);
            13: check_eq("q_drain", 32'(state_code), 32'd4);
            16: check_eq("q_fill2", 32'(state_code), 32'd1);
            20: check_eq("q_rinse", 32'(state_code), 32'd5);
            26: check_eq("q_drain2", 32'(state_code), 32'd4);
            29: check_eq("q_spin", 32'(state_code), 32'd6);
            34: check_eq("q_done", 32'(done), 32'd1);
            default: ;
         endcase
         if (c + 1 >= 5 && c + 1 <= 8) check_eq("q_dir", 32'(motor_dir), 32'(qdir[c - 4]));
      end
      finish_run();

      // Pause at cycle 7, resume at cycle 20.
      for (int c = 0; c < 28; c++) begin
         tick(0, (c == 0) || (c == 7) || (c == 20), 2'b00, 0);
         case (c + 1)
            8:  check_eq("p_paused", 32'(paused), 32'd1);
            20: check_eq("p_still", 32'({paused, motor}), 32'b10);
            21: check_eq("p_resume", 32'({paused, state_code}), 32'h03);
            26: check_eq("p_wash_last", 32'(state_code), 32'd3);
            27: check_eq("p_drain", 32'(state_code), 32'd4);
            default: ;
         endcase
      end
      finish_run();

      // Door open from cycle 17, ignored edge at 20, close at 23, resume edge at 25.
      for (int c = 0; c < 30; c++) begin
         tick(0, (c == 0) || (c == 20) || (c == 25), 2'b00, (c >= 17) && (c <= 22));
         case (c + 1)
            18: check_eq("d_paused", 32'({paused, water_valve, state_code}), 32'h21);
            21: check_eq("d_ignored", 32'(paused), 32'd1);
            25: check_eq("d_no_auto", 32'(paused), 32'd1);
            26: check_eq("d_resume", 32'({paused, water_valve, state_code}), 32'h11);
            28: check_eq("d_fill_last", 32'(state_code), 32'd1);
            29: check_eq("d_rinse", 32'(state_code), 32'd5);
            default: ;
         endcase
      end
      finish_run();

      // Reset mid-run at cycle 10 with start_pause held high.
      for (int c = 0; c < 18; c++) begin
         tick(c == 10, (c == 0) || (c >= 10 && c <= 14) || (c == 16), 2'b01, 0);
         case (c + 1)
            11: check_eq("r_idle", 32'(obs), 32'd0);
            15: check_eq("r_no_start", 32'(state_code), 32'd0);
            17: check_eq("r_restart", 32'(state_code), 32'd1);
            default: ;
         endcase
      end
      finish_run();

      // Heavy mode.
      for (int c = 0; c < 34; c++) begin
         tick(0, c == 0, 2'b10, 0);
`ifdef WASH_SOAK_EN
         case (c + 1)
            5:  check_eq("h_soak", 32'(state_code), 32'd2);
            9:  check_eq("h_wash", 32'(state_code), 32'd3);
            32: check_eq("h_wash_last", 32'(state_code), 32'd3);
            33: check_eq("h_drain", 32'(state_code), 32'd4);
            default: ;
         endcase
`else
         case (c + 1)
            5:  check_eq("h_wash", 32'(state_code), 32'd3);
            28: check_eq("h_wash_last", 32'(state_code), 32'd3);
            29: check_eq("h_drain", 32'(state_code), 32'd4);
            default: ;
         endcase
`endif
      end
      finish_run();

      // Spin-only starts in DRAIN.
      tick(0, 1, 2'b11, 0);
      check_eq("s_drain", 32'(state_code), 32'd4);
      finish_run();

      // Randomized traffic against the model.
      door_hold = 0;
      for (int c = 0; c < 5000; c++) begin
         bit d;
         if (door_hold > 0) begin
            d = 1; door_hold--;
         end else if ($urandom_range(0, 119) == 0) begin
            door_hold = $urandom_range(1, 6);
            d = 1;
         end else begin
            d = 0;
         end
         tick($urandom_range(0, 799) == 0, $urandom_range(0, 9) == 0,
              2'($urandom_range(0, 3)), d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
